relu_writeback: RTL and testbench
=================================

// Module: relu_writeback
// PURPOSE
//  Stage directly downstream of the bias stage. Takes the 512-bit bias-added result beats.
//  Applies per-lane ReLU when enabled and stages the beats in a 2-entry FIFO.
//  Writes them to the output buffer at sequential addresses from addr_start_o.
//  Pulses done after out_piece beats have been written.
// PARAMETERS
//  ADDR_WIDTH  8    output-buffer address width
//  DATA_WIDTH  16   lane width, signed two's complement
//  BUS_WIDTH   512  beat width; LANES = BUS_WIDTH/DATA_WIDTH (32 by default)
// PORTS
//  clk               in   1           clock, all logic on rising edge
//  rst               in   1           synchronous, active-low reset
//  calculate_enble   in   1           start pulse from schedule: latch config, enter RUN
//  relu_en           in   1           from decoder, sampled at start: 1=ReLU, 0=pass-through
//  out_piece         in   8           from decoder: beats expected this pass
//  addr_start_o      in   ADDR_WIDTH  from decoder: first output-buffer address
//  bias_result       in   BUS_WIDTH   from bias stage
//  bias_result_valid in   1           beat qualifier; no backpressure to bias stage
//  obuf_ready        in   1           output buffer accepts a write this cycle
//  o_wr_en           out  1           output-buffer write strobe
//  o_wr_addr         out  ADDR_WIDTH  write address
//  o_wr_data         out  BUS_WIDTH   write data
//  o_done            out  1           one-cycle pulse when the pass completes
//  o_overflow        out  1           sticky: a beat was dropped (FIFO full, or arrived in IDLE)
// BEHAVIOUR
//  Reset (rst=0 at a clock edge): state=IDLE, FIFO emptied, counters=0, all outputs 0.
//   Reset mid-pass aborts the pass with no o_done.
//  FSM: IDLE -> RUN on calculate_enble. IDLE -> DONE if calculate_enble and out_piece==0.
//   RUN -> DONE in the cycle the out_piece-th write is accepted.
//   DONE -> IDLE after 1 cycle; o_done=1 only in DONE.
//   calculate_enble in RUN or DONE is ignored.
//  At start: latch relu_en, out_piece, addr_start_o. Clear wr_cnt. Clear o_overflow.
//  ReLU per lane i: out[i] = (relu_en && in[i][MSB]) ? 0 : in[i]. Pure function, no saturation.
//  FIFO: 2 entries, registered, first-word-fall-through.
//   A push at edge N makes the head visible from cycle N+1.
//   Push = bias_result_valid && state==RUN. Pop = o_wr_en.
//   Push and pop in the same cycle are legal at any occupancy, including full (count unchanged).
//   Push when full with no pop: beat dropped, o_overflow=1, wr_cnt not advanced.
//   bias_result_valid in IDLE or DONE: beat dropped, o_overflow=1.
//  Write port: o_wr_en = FIFO non-empty && obuf_ready && state==RUN.
//   o_wr_data = FIFO head. o_wr_addr = latched addr_start_o + wr_cnt, modulo 2^ADDR_WIDTH.
//   The address wraps, so 0xFF is followed by 0x00.
//  Latency: with FIFO empty and obuf_ready=1, valid beat at cycle N -> o_wr_en at cycle N+1.
//   Sustains 1 beat/cycle.
//  wr_cnt increments on each accepted write.
//   The write with wr_cnt==out_piece-1 moves state to DONE the next cycle.
//   Surplus FIFO contents are discarded on entry to DONE and set o_overflow.
//  o_wr_en is 0 whenever obuf_ready=0. Data in the FIFO is held unchanged while stalled.
// TESTING
//  T1: relu_en=1, out_piece=3, addr_start_o=0x10, lanes {-5,0,7,0x8000}, ready=1
//      -> writes at 0x11,0x12,0x13? No: writes at 0x10,0x11,0x12 with lanes {0,0,7,0};
//      o_done 1 cycle after the 3rd write.
//  T2: same beats with relu_en=0 -> data written unchanged ({-5,0,7,0x8000}); o_overflow=0.
//  T3: addr_start_o=0xFE, out_piece=4, back-to-back valid -> addresses 0xFE,0xFF,0x00,0x01.
//  T4: out_piece=4, obuf_ready=0 while 3 beats arrive -> 2 beats held, 3rd dropped, o_overflow=1;
//      release ready -> 2 writes, no o_done until a 4th valid write.
//  T5: rst=0 asserted mid-pass after 2 of 5 writes -> all outputs 0 the next cycle, no o_done;
//      a new start runs cleanly from addr_start_o.
//  T6: out_piece=0 with start -> o_done the next cycle, no writes; valid beats in IDLE set o_overflow.

Source files
------------

// File: rtl/relu_writeback.sv
// ReLU + write-back stage: per-lane ReLU on incoming bias beats, 2-entry FWFT staging FIFO,
// and sequential output-buffer writes with a done pulse after out_piece accepted writes.
module relu_writeback #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  calculate_enble,
  input  logic                  relu_en,
  input  logic [7:0]            out_piece,
  input  logic [ADDR_WIDTH-1:0] addr_start_o,
  input  logic [BUS_WIDTH-1:0]  bias_result,
  input  logic                  bias_result_valid,
  input  logic                  obuf_ready,
  output logic                  o_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [BUS_WIDTH-1:0]  o_wr_data,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam int LANES = BUS_WIDTH / DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic                  relu_q;
  logic [7:0]            piece_q;
  logic [7:0]            wr_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  overflow_q;

  logic [BUS_WIDTH-1:0]  mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;

  logic [BUS_WIDTH-1:0]  relu_data;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  last_wr;
  logic [1:0]            count_d;
  logic                  drop;

  // Lanes are zeroed on a set sign bit only when ReLU was enabled for this pass.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign relu_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      (relu_q && bias_result[gi*DATA_WIDTH + DATA_WIDTH - 1]) ? '0
                                                               : bias_result[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign full    = (count_q == 2'd2);
  assign o_wr_en = (count_q != 2'd0) && obuf_ready && (state_q == RUN);
  assign pop     = o_wr_en;
  assign push    = bias_result_valid && (state_q == RUN);
  assign push_ok = push && (!full || pop);
  assign last_wr = pop && (wr_cnt_q == piece_q - 8'd1);
  assign count_d = count_q + {1'b0, push_ok} - {1'b0, pop};
  assign drop    = (bias_result_valid && (state_q != RUN)) || (push && full && !pop);

  assign o_wr_addr  = addr_q + ADDR_WIDTH'(wr_cnt_q);
  assign o_wr_data  = o_wr_en ? mem_q[rd_ptr_q] : '0;
  assign o_done     = (state_q == DONE);
  assign o_overflow = overflow_q;

  // Storage needs no reset: it is only observed through o_wr_data, which is gated by o_wr_en.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= relu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      relu_q     <= 1'b0;
      piece_q    <= '0;
      wr_cnt_q   <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        wr_cnt_q <= wr_cnt_q + 8'd1;
      end
      count_q <= count_d;

      case (state_q)
        IDLE: begin
          if (calculate_enble) begin
            relu_q     <= relu_en;
            piece_q    <= out_piece;
            addr_q     <= addr_start_o;
            wr_cnt_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= (out_piece == 8'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (last_wr) begin
            state_q <= DONE;
            // Beats still queued beyond the requested count are discarded.
            if (count_d != 2'd0) begin
              count_q    <= '0;
              wr_ptr_q   <= 1'b0;
              rd_ptr_q   <= 1'b0;
              overflow_q <= 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // A dropped beat wins over the clear at start.
      if (drop) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_relu_writeback.sv
// Directed bench for relu_writeback: table of single-beat ReLU vectors plus multi-cycle
// sequences for address wrap, stall/overflow, mid-pass reset and zero-length passes.
module tb_relu_writeback;

  logic         clk = 1'b0;
  logic         rst;
  logic         calculate_enble;
  logic         relu_en;
  logic [7:0]   out_piece;
  logic [7:0]   addr_start_o;
  logic [511:0] bias_result;
  logic         bias_result_valid;
  logic         obuf_ready;
  logic         o_wr_en;
  logic [7:0]   o_wr_addr;
  logic [511:0] o_wr_data;
  logic         o_done;
  logic         o_overflow;

  relu_writeback dut (
    .clk(clk), .rst(rst), .calculate_enble(calculate_enble), .relu_en(relu_en),
    .out_piece(out_piece), .addr_start_o(addr_start_o), .bias_result(bias_result),
    .bias_result_valid(bias_result_valid), .obuf_ready(obuf_ready), .o_wr_en(o_wr_en),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_done(o_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0]   wr_addr_q [$];
  logic [511:0] wr_data_q [$];
  int           wr_cyc_q  [$];
  int           done_q    [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_wr_en) begin
      wr_addr_q.push_back(o_wr_addr);
      wr_data_q.push_back(o_wr_data);
      wr_cyc_q.push_back(cyc);
      $display("cyc %0d write addr=%02h data[63:0]=%016h", cyc, o_wr_addr, o_wr_data[63:0]);
    end
    if (o_done) done_q.push_back(cyc);
  end

  typedef struct {
    logic        relu;
    logic [63:0] in_pat;
    logic [63:0] exp_pat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] rep(input logic [63:0] p);
    return {8{p}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_q.delete();
  endtask

  task automatic start_pass(input logic r, input logic [7:0] p, input logic [7:0] a);
    calculate_enble = 1'b1;
    relu_en = r;
    out_piece = p;
    addr_start_o = a;
    tick();
    calculate_enble = 1'b0;
    relu_en = 1'b0;
    out_piece = 8'd0;
    addr_start_o = 8'd0;
  endtask

  task automatic send(input logic [511:0] d);
    bias_result = d;
    bias_result_valid = 1'b1;
    tick();
    bias_result_valid = 1'b0;
    bias_result = '0;
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [7:0] a, input logic [511:0] d);
    if (idx < wr_addr_q.size()) begin
      chk({name, "_addr"}, wr_addr_q[idx], a);
      chk({name, "_data"}, wr_data_q[idx], d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    tbl[0] = '{1'b1, 64'h8000_0007_0000_FFFB, 64'h0000_0007_0000_0000};
    tbl[1] = '{1'b1, 64'h8001_0001_FFFF_7FFF, 64'h0000_0001_0000_7FFF};
    tbl[2] = '{1'b1, 64'h1234_F234_0000_7000, 64'h1234_0000_0000_7000};
    tbl[3] = '{1'b0, 64'h8000_0007_0000_FFFB, 64'h8000_0007_0000_FFFB};
    tbl[4] = '{1'b0, 64'h8001_0001_FFFF_7FFF, 64'h8001_0001_FFFF_7FFF};
    tbl[5] = '{1'b0, 64'h1234_F234_0000_7000, 64'h1234_F234_0000_7000};

    rst = 1'b0;
    calculate_enble = 1'b0;
    relu_en = 1'b0;
    out_piece = 8'd0;
    addr_start_o = 8'd0;
    bias_result = '0;
    bias_result_valid = 1'b0;
    obuf_ready = 1'b1;
    tick();
    tick();
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_addr", o_wr_addr, 0);
    chk("rst_data", o_wr_data, 0);
    chk("rst_done", o_done, 0);
    chk("rst_ovf", o_overflow, 0);
    rst = 1'b1;
    tick();

    // Table: one-beat passes, one per vector.
    for (int i = 0; i < 6; i++) begin
      clear_log();
      start_pass(tbl[i].relu, 8'd1, 8'h20 + 8'(i));
      send(rep(tbl[i].in_pat));
      repeat (3) tick();
      chk($sformatf("vec%0d_nwr", i), wr_addr_q.size(), 1);
      chk_wr($sformatf("vec%0d", i), 0, 8'h20 + 8'(i), rep(tbl[i].exp_pat));
      chk($sformatf("vec%0d_done", i), done_q.size(), 1);
      chk($sformatf("vec%0d_ovf", i), o_overflow, 0);
    end

    // T1 / T2: three-beat passes at 0x10, ReLU on then off.
    for (int t = 0; t < 2; t++) begin
      clear_log();
      start_pass(t == 0, 8'd3, 8'h10);
      for (int b = 0; b < 3; b++) send(rep(tbl[t*3 + b].in_pat));
      repeat (4) tick();
      chk($sformatf("t%0d_nwr", t + 1), wr_addr_q.size(), 3);
      for (int b = 0; b < 3; b++)
        chk_wr($sformatf("t%0d_w%0d", t + 1, b), b, 8'h10 + 8'(b), rep(tbl[t*3 + b].exp_pat));
      chk($sformatf("t%0d_ndone", t + 1), done_q.size(), 1);
      if (done_q.size() == 1 && wr_cyc_q.size() == 3)
        chk($sformatf("t%0d_done_cyc", t + 1), done_q[0], wr_cyc_q[2] + 1);
      chk($sformatf("t%0d_ovf", t + 1), o_overflow, 0);
    end

    // T3: address wrap 0xFE,0xFF,0x00,0x01.
    clear_log();
    start_pass(1'b0, 8'd4, 8'hFE);
    for (int b = 0; b < 4; b++) send(rep(tbl[3 + (b % 3)].in_pat));
    repeat (4) tick();
    chk("t3_nwr", wr_addr_q.size(), 4);
    chk_wr("t3_w0", 0, 8'hFE, rep(tbl[3].exp_pat));
    chk_wr("t3_w1", 1, 8'hFF, rep(tbl[4].exp_pat));
    chk_wr("t3_w2", 2, 8'h00, rep(tbl[5].exp_pat));
    chk_wr("t3_w3", 3, 8'h01, rep(tbl[3].exp_pat));
    chk("t3_ndone", done_q.size(), 1);

    // T4: stall with three beats -> two held, third dropped.
    clear_log();
    obuf_ready = 1'b0;
    start_pass(1'b0, 8'd4, 8'h30);
    send(rep(tbl[3].in_pat));
    send(rep(tbl[4].in_pat));
    send(rep(tbl[5].in_pat));
    chk("t4_stall_nwr", wr_addr_q.size(), 0);
    chk("t4_stall_ovf", o_overflow, 1);
    obuf_ready = 1'b1;
    repeat (4) tick();
    chk("t4_nwr2", wr_addr_q.size(), 2);
    chk_wr("t4_w0", 0, 8'h30, rep(tbl[3].exp_pat));
    chk_wr("t4_w1", 1, 8'h31, rep(tbl[4].exp_pat));
    chk("t4_nodone2", done_q.size(), 0);
    send(rep(64'h0123_4567_89AB_CDEF));
    repeat (3) tick();
    chk("t4_nodone3", done_q.size(), 0);
    chk_wr("t4_w2", 2, 8'h32, rep(64'h0123_4567_89AB_CDEF));
    send(rep(64'hFEDC_BA98_7654_3210));
    repeat (3) tick();
    chk("t4_nwr4", wr_addr_q.size(), 4);
    chk_wr("t4_w3", 3, 8'h33, rep(64'hFEDC_BA98_7654_3210));
    chk("t4_done", done_q.size(), 1);
    chk("t4_ovf_sticky", o_overflow, 1);

    // T5: reset during the second write of a five-beat pass.
    clear_log();
    start_pass(1'b1, 8'd5, 8'h40);
    send(rep(tbl[0].in_pat));
    send(rep(tbl[1].in_pat));
    bias_result = rep(tbl[2].in_pat);
    bias_result_valid = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bias_result_valid = 1'b0;
    bias_result = '0;
    chk("t5_wr_en", o_wr_en, 0);
    chk("t5_addr", o_wr_addr, 0);
    chk("t5_data", o_wr_data, 0);
    chk("t5_done", o_done, 0);
    chk("t5_ovf", o_overflow, 0);
    chk("t5_nwr", wr_addr_q.size(), 2);
    repeat (4) tick();
    chk("t5_nodone", done_q.size(), 0);
    clear_log();
    start_pass(1'b1, 8'd2, 8'h50);
    send(rep(tbl[1].in_pat));
    send(rep(tbl[2].in_pat));
    repeat (4) tick();
    chk("t5b_nwr", wr_addr_q.size(), 2);
    chk_wr("t5b_w0", 0, 8'h50, rep(tbl[1].exp_pat));
    chk_wr("t5b_w1", 1, 8'h51, rep(tbl[2].exp_pat));
    chk("t5b_done", done_q.size(), 1);
    chk("t5b_ovf", o_overflow, 0);

    // T6: zero-length pass, then a stray beat in IDLE.
    clear_log();
    s = cyc;
    start_pass(1'b0, 8'd0, 8'h60);
    repeat (2) tick();
    chk("t6_ndone", done_q.size(), 1);
    if (done_q.size() == 1) chk("t6_done_cyc", done_q[0], s + 1);
    chk("t6_nwr", wr_addr_q.size(), 0);
    chk("t6_ovf0", o_overflow, 0);
    send(rep(tbl[0].in_pat));
    tick();
    chk("t6_ovf1", o_overflow, 1);
    chk("t6_nwr_idle", wr_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
